// File: rtl/alu_sequencer_if.sv
// Bundles the instruction handshake, the external ALU operand/result bus and the
// status/debug signals used by alu_sequencer.
interface alu_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        instr_ready;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic [15:0] alu_imm;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        done;
  logic        illegal;
  logic        carry_flag;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  modport slave (
    input  instr_valid, instr_data, alu_result, alu_carry, dbg_addr,
    output instr_ready, alu_opcode, alu_src1, alu_src2, alu_imm,
           done, illegal, carry_flag, dbg_data
  );

  modport master (
    output instr_valid, instr_data, alu_result, alu_carry, dbg_addr,
    input  instr_ready, alu_opcode, alu_src1, alu_src2, alu_imm,
           done, illegal, carry_flag, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer (IDLE/DECODE/EXEC/WB) driving an external
// combinational ALU, with an 8 x 16 register file and a sticky carry flag.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [3:0]  opcode_q;
  logic [15:0] src1_q, src2_q;
  logic [5:0]  imm_q;
  logic [15:0] result_q;
  logic        carry_res_q;
  logic        carry_flag_q;
  logic [15:0] rf_q [8];

  logic ready_c, done_c, illegal_c;
  logic accept, latch_ops, latch_res, rf_we;
  logic legal;

  // Opcodes 0000-1000 retire with a write; everything above is illegal.
  assign legal = (opcode_q <= 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    accept    = 1'b0;
    latch_ops = 1'b0;
    latch_res = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        latch_ops = 1'b1;
        state_d   = EXEC;
      end
      EXEC: begin
        latch_res = 1'b1;
        state_d   = WB;
      end
      WB: begin
        done_c    = 1'b1;
        illegal_c = ~legal;
        rf_we     = legal;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured in DECODE, so rd == rs1/rs2 sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      opcode_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      imm_q        <= '0;
      result_q     <= '0;
      carry_res_q  <= 1'b0;
      carry_flag_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (accept) instr_q <= bus.instr_data;
      if (latch_ops) begin
        opcode_q <= instr_q[15:12];
        src1_q   <= rf_q[instr_q[8:6]];
        src2_q   <= rf_q[instr_q[5:3]];
        imm_q    <= instr_q[5:0];
      end
      if (latch_res) begin
        result_q    <= bus.alu_result;
        carry_res_q <= bus.alu_carry;
      end
      if (rf_we) begin
        rf_q[instr_q[11:9]] <= result_q;
        carry_flag_q        <= carry_res_q;
      end
    end
  end

  assign bus.instr_ready = ready_c;
  assign bus.done        = done_c;
  assign bus.illegal     = illegal_c;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_src1    = src1_q;
  assign bus.alu_src2    = src2_q;
  assign bus.alu_imm     = {10'd0, imm_q};
  assign bus.carry_flag  = carry_flag_q;
  assign bus.dbg_data    = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a small ALU model on the bus, a vector table
// of single instructions, plus back-to-back and reset-abort sequences.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 DIV, 8 LDI
  logic [16:0] wide;
  logic [31:0] prod;
  always_comb begin
    wide           = '0;
    prod           = bus.alu_src1 * bus.alu_src2;
    bus.alu_result = 16'hDEAD;
    bus.alu_carry  = 1'b0;
    case (bus.alu_opcode)
      4'd0: begin
        wide = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
        bus.alu_result = wide[15:0];
        bus.alu_carry  = wide[16];
      end
      4'd1: begin
        wide = {1'b0, bus.alu_src1} - {1'b0, bus.alu_src2};
        bus.alu_result = wide[15:0];
        bus.alu_carry  = wide[16];
      end
      4'd2: bus.alu_result = bus.alu_src1 & bus.alu_src2;
      4'd3: bus.alu_result = bus.alu_src1 | bus.alu_src2;
      4'd4: bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
      4'd5: bus.alu_result = bus.alu_src1 << bus.alu_src2[3:0];
      4'd6: bus.alu_result = prod[15:0];
      4'd7: bus.alu_result = (bus.alu_src2 == 16'd0) ? 16'd0 : bus.alu_src1 / bus.alu_src2;
      4'd8: bus.alu_result = bus.alu_imm;
      default: ;
    endcase
  end

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic [2:0]  rreg;
    logic [15:0] exp_val;
    logic        exp_c;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
    bus.dbg_addr = a;
    #1;
    v = bus.dbg_data;
  endtask

  // Issues one instruction and follows it to the IDLE state after write-back.
  task automatic run_instr(input logic [15:0] ins, output int lat,
                           output logic ill, output int npulse);
    int w = 0;
    while (!bus.instr_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr_data  = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'hFFFF;
    lat = -1; ill = 1'b0; npulse = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.done) begin
        npulse++;
        lat = c;
        ill = bus.illegal;
      end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int          lat, np, ndone, idx, prev;
    logic        ill, acc;
    logic [15:0] v;
    logic [15:0] b2b [4];

    vecs[0]  = '{"ldi_r1_5",     16'h8205, 3'd1, 16'h0005, 1'b0, 1'b0};
    vecs[1]  = '{"ldi_r2_3",     16'h8403, 3'd2, 16'h0003, 1'b0, 1'b0};
    vecs[2]  = '{"sub_r3",       16'h1688, 3'd3, 16'hFFFE, 1'b1, 1'b0};
    vecs[3]  = '{"add_r4",       16'h0850, 3'd4, 16'h0008, 1'b0, 1'b0};
    vecs[4]  = '{"div_r5_5by3",  16'h7A50, 3'd5, 16'h0001, 1'b0, 1'b0};
    vecs[5]  = '{"div_r5_by0",   16'h7A40, 3'd5, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{"ldi_r7_16",    16'h8E10, 3'd7, 16'h0010, 1'b0, 1'b0};
    vecs[7]  = '{"mul_r1_256",   16'h63F8, 3'd1, 16'h0100, 1'b0, 1'b0};
    vecs[8]  = '{"ldi_r6_1",     16'h8C01, 3'd6, 16'h0001, 1'b0, 1'b0};
    vecs[9]  = '{"mul_r6_trunc", 16'h6C48, 3'd6, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{"sub_r3_borrow",16'h1688, 3'd3, 16'hFF03, 1'b1, 1'b0};
    vecs[11] = '{"ill_f_r1",     16'hF200, 3'd1, 16'h0100, 1'b1, 1'b1};
    vecs[12] = '{"ill_9_r5",     16'h9A00, 3'd5, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{"ldi_r1_7",     16'h8207, 3'd1, 16'h0007, 1'b0, 1'b0};
    vecs[14] = '{"add_r1_self",  16'h0248, 3'd1, 16'h000E, 1'b0, 1'b0};
    vecs[15] = '{"ldi_r0_42",    16'h802A, 3'd0, 16'h002A, 1'b0, 1'b0};
    vecs[16] = '{"xor_r2",       16'h4408, 3'd2, 16'h0024, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0000;
    bus.dbg_addr    = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   bus.instr_ready, 1);
    chk("rst_done",    bus.done, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_carry",   bus.carry_flag, 0);
    chk("rst_opcode",  bus.alu_opcode, 0);
    chk("rst_src1",    bus.alu_src1, 0);
    chk("rst_src2",    bus.alu_src2, 0);
    chk("rst_imm",     bus.alu_imm, 0);
    read_reg(3'd7, v);
    chk("rst_r7", v, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].ins, lat, ill, np);
      chk({vecs[i].name, "_latency"}, lat, 2);
      chk({vecs[i].name, "_npulse"},  np, 1);
      chk({vecs[i].name, "_illegal"}, ill, vecs[i].exp_ill);
      chk({vecs[i].name, "_ready"},   bus.instr_ready, 1);
      chk({vecs[i].name, "_carry"},   bus.carry_flag, vecs[i].exp_c);
      read_reg(vecs[i].rreg, v);
      chk({vecs[i].name, "_value"},   v, vecs[i].exp_val);
    end

    // Valid held high: one acceptance every 4 cycles, each instruction once.
    b2b[0] = 16'h8601; b2b[1] = 16'h8802; b2b[2] = 16'h8A03; b2b[3] = 16'h8C04;
    idx = 0; prev = 0; ndone = 0;
    bus.instr_valid = 1'b1;
    bus.instr_data  = b2b[0];
    for (int cyc = 0; cyc < 24 && idx < 4; cyc++) begin
      acc = bus.instr_ready;
      @(posedge clk); #1;
      if (bus.done) ndone++;
      if (acc) begin
        if (idx > 0) chk("b2b_spacing", cyc - prev, 4);
        prev = cyc;
        idx++;
        if (idx < 4) bus.instr_data = b2b[idx];
        else bus.instr_valid = 1'b0;
      end
    end
    chk("b2b_accepts", idx, 4);
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("b2b_done_count", ndone, 4);
    for (int r = 0; r < 4; r++) begin
      read_reg(3'(r + 3), v);
      chk("b2b_value", v, 16'(r + 1));
    end

    // Reset asserted while ADD r2=r1+r1 is in EXEC.
    bus.instr_valid = 1'b1;
    bus.instr_data  = 16'h0448;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", bus.instr_ready, 0);
    rst_n = 1'b0;
    #1;
    ndone = 0;
    chk("abort_ready", bus.instr_ready, 1);
    chk("abort_carry", bus.carry_flag, 0);
    chk("abort_src1",  bus.alu_src1, 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    read_reg(3'd2, v);
    chk("abort_r2", v, 0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 16'h8403;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk("post_rst_accept", bus.instr_ready, 0);
    chk("post_rst_no_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_done", bus.done, 1);
    @(posedge clk); #1;
    read_reg(3'd2, v);
    chk("post_rst_r2", v, 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
